// File: rtl/prescaler_pkg.sv
// Shared definitions for the rate prescaler.
//   CNT_W_DEF     default half-period / counter width
//   N_RATES_DEF   default number of selectable rates
//   DEF_HALF_DEF  reset half-period table, index 7 (MSB slice) down to 0
//   state_e       divider state encoding
//   half_for_hz() half-period in clk cycles for a wanted output frequency
package prescaler_pkg;

    localparam int CNT_W_DEF   = 24;
    localparam int N_RATES_DEF = 8;

    // At 50 MHz: idx7..idx0 = 100, 75, 50, 35, 25, 20, 10, 5 Hz.
    localparam logic [N_RATES_DEF*CNT_W_DEF-1:0] DEF_HALF_DEF = {
        24'd250_000,   24'd333_333,   24'd500_000,   24'd714_286,
        24'd1_000_000, 24'd1_250_000, 24'd2_500_000, 24'd5_000_000
    };

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // A zero frequency has no meaningful half-period; return the largest
    // representable value so the output is as slow as possible.
    function automatic logic [CNT_W_DEF-1:0] half_for_hz(input int unsigned clk_hz,
                                                          input int unsigned f_hz);
        if (f_hz == 0) begin
            return '1;
        end
        return CNT_W_DEF'(clk_hz / (2 * f_hz));
    endfunction

endpackage

// File: rtl/rate_table.sv
// Runtime-writable half-period table.
//   clk, rst      clock, asynchronous active-low reset (restores DEF_HALF)
//   we/wr_idx/wr_half  single write port, applied at the clock edge
//   rd_idx        combinational read index
//   rd_half       entry at rd_idx (0 when rd_idx is out of range)
//   rd_valid      rd_idx addresses a real entry
module rate_table
    import prescaler_pkg::*;
#(
    parameter int                          N_RATES  = N_RATES_DEF,
    parameter int                          SEL_W    = 3,
    parameter int                          CNT_W    = CNT_W_DEF,
    parameter logic [N_RATES*CNT_W-1:0]    DEF_HALF = DEF_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [SEL_W-1:0] wr_idx,
    input  logic [CNT_W-1:0] wr_half,
    input  logic [SEL_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_half,
    output logic             rd_valid
);

    logic [N_RATES-1:0][CNT_W-1:0] tbl_q, tbl_d;

    // Out-of-range indices only exist when N_RATES is not a power of two.
    always_comb begin
        tbl_d = tbl_q;
        if (we && (32'(wr_idx) < N_RATES)) begin
            tbl_d[wr_idx] = wr_half;
        end
    end

    always_comb begin
        rd_valid = (32'(rd_idx) < N_RATES);
        rd_half  = '0;
        if (rd_valid) begin
            rd_half = tbl_q[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tbl_q <= DEF_HALF;
        end else begin
            tbl_q <= tbl_d;
        end
    end

endmodule

// File: rtl/rate_prescaler.sv
// Shared down-divider producing a 50 % duty clk_driver at a selectable rate.
//   clk, rst     clock, asynchronous active-low reset
//   en           run enable, sampled in IDLE and at period boundaries
//   set_rate     requested rate index, sampled at the same points
//   cfg_we/cfg_idx/cfg_half  half-period table write port
//   clk_driver   divided square output
//   tick         one-cycle pulse in the cycle clk_driver rises
//   sw_done      one-cycle pulse when a different rate index becomes active
//   active_sel   rate index in use
//   running      divider is counting
// Half-period and rate only change at a 1->0 edge of clk_driver, so the
// output never produces a runt pulse.
module rate_prescaler
    import prescaler_pkg::*;
#(
    parameter int                          N_RATES  = N_RATES_DEF,
    parameter int                          SEL_W    = 3,
    parameter int                          CNT_W    = CNT_W_DEF,
    parameter logic [N_RATES*CNT_W-1:0]    DEF_HALF = DEF_HALF_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] set_rate,
    input  logic             cfg_we,
    input  logic [SEL_W-1:0] cfg_idx,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             clk_driver,
    output logic             tick,
    output logic             sw_done,
    output logic [SEL_W-1:0] active_sel,
    output logic             running
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             drv_q, drv_d;
    logic             tick_q, tick_d;
    logic             sw_q, sw_d;
    logic             run_q, run_d;

    logic [CNT_W-1:0] tbl_half;
    logic             tbl_vld;
    logic [CNT_W-1:0] h_eff;
    logic             at_end;

    // Read port follows set_rate; the write lands at the edge, so a reload
    // in the same cycle as a write sees the old entry.
    rate_table #(
        .N_RATES  (N_RATES),
        .SEL_W    (SEL_W),
        .CNT_W    (CNT_W),
        .DEF_HALF (DEF_HALF)
    ) u_table (
        .clk      (clk),
        .rst      (rst),
        .we       (cfg_we),
        .wr_idx   (cfg_idx),
        .wr_half  (cfg_half),
        .rd_idx   (set_rate),
        .rd_half  (tbl_half),
        .rd_valid (tbl_vld)
    );

    // A stored 0 behaves as 1 (output clk/2).
    assign h_eff  = (half_q == '0) ? CNT_W'(1) : half_q;
    assign at_end = (cnt_q == (h_eff - CNT_W'(1)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        sel_d   = sel_q;
        drv_d   = drv_q;
        run_d   = run_q;
        tick_d  = 1'b0;
        sw_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                drv_d = 1'b0;
                run_d = 1'b0;
                if (en) begin
                    state_d = RUN;
                    run_d   = 1'b1;
                    if (tbl_vld) begin
                        half_d = tbl_half;
                        sel_d  = set_rate;
                        sw_d   = (set_rate != sel_q);
                    end
                end
            end
            RUN: begin
                if (at_end) begin
                    cnt_d = '0;
                    drv_d = ~drv_q;
                    if (!drv_q) begin
                        tick_d = 1'b1;
                    end else if (!en) begin
                        // Falling edge is the period boundary: park low.
                        state_d = IDLE;
                        run_d   = 1'b0;
                    end else if (tbl_vld) begin
                        half_d = tbl_half;
                        sel_d  = set_rate;
                        sw_d   = (set_rate != sel_q);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= DEF_HALF[CNT_W-1:0];
            sel_q   <= '0;
            drv_q   <= 1'b0;
            tick_q  <= 1'b0;
            sw_q    <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            sel_q   <= sel_d;
            drv_q   <= drv_d;
            tick_q  <= tick_d;
            sw_q    <= sw_d;
            run_q   <= run_d;
        end
    end

    assign clk_driver = drv_q;
    assign tick       = tick_q;
    assign sw_done    = sw_q;
    assign active_sel = sel_q;
    assign running    = run_q;

endmodule

// File: tb/tb_rate_prescaler.sv
// Scoreboard bench: each stimulus step pushes the periods (rise interval,
// high width) and sw_done selections it implies; a negedge monitor pops
// and compares them as the DUT produces rises, falls and sw_done pulses.
module tb_rate_prescaler;
    import prescaler_pkg::*;

    localparam int N_RATES = 8;
    localparam int SEL_W   = 3;
    localparam int CNT_W   = 24;
    localparam logic [N_RATES*CNT_W-1:0] TB_HALF =
        {24'd8, 24'd7, 24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1};

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic [SEL_W-1:0] set_rate = '0;
    logic             cfg_we = 1'b0;
    logic [SEL_W-1:0] cfg_idx = '0;
    logic [CNT_W-1:0] cfg_half = '0;
    logic             clk_driver, tick, sw_done, running;
    logic [SEL_W-1:0] active_sel;

    typedef struct {
        int intv;
        int high;
    } per_t;

    per_t exp_q[$];
    int   sw_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   start_cyc = 0;

    rate_prescaler #(
        .N_RATES  (N_RATES),
        .SEL_W    (SEL_W),
        .CNT_W    (CNT_W),
        .DEF_HALF (TB_HALF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .set_rate   (set_rate),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_half   (cfg_half),
        .clk_driver (clk_driver),
        .tick       (tick),
        .sw_done    (sw_done),
        .active_sel (active_sel),
        .running    (running)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint obs, input longint exp_v);
        n_chk++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Monitor: interval from the later of last rise / enable point.
    logic prev_drv = 1'b0;
    int   rise_cyc = 0;
    int   exp_high = 0;
    per_t e;

    always @(negedge clk) begin
        if (!rst) begin
            prev_drv = 1'b0;
            rise_cyc = 0;
            exp_high = 0;
        end else begin
            if ((!prev_drv && clk_driver) || tick) begin
                chk("tick_on_rise", tick, (!prev_drv && clk_driver));
                if (tick) begin
                    if (exp_q.size() == 0) begin
                        chk("tick_unexpected", cyc, -1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rise_interval",
                            cyc - ((start_cyc > rise_cyc) ? start_cyc : rise_cyc), e.intv);
                        exp_high = e.high;
                    end
                    rise_cyc = cyc;
                end
            end
            if (prev_drv && !clk_driver) begin
                chk("high_width", cyc - rise_cyc, exp_high);
            end
            if (sw_done) begin
                if (sw_q.size() == 0) chk("sw_unexpected", active_sel, -1);
                else                  chk("sw_sel", active_sel, sw_q.pop_front());
            end
            prev_drv = clk_driver;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_per(input int intv, input int high);
        per_t p;
        p.intv = intv;
        p.high = high;
        exp_q.push_back(p);
    endtask

    // Returns just after the edge at which clk_driver went high.
    task automatic wait_rise(input string tag);
        logic p;
        bit   found;
        p     = clk_driver;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk);
            #1;
            if (!p && clk_driver) found = 1'b1;
            p = clk_driver;
        end
        if (!found) chk({tag, "_rise_timeout"}, 1, 0);
    endtask

    task automatic wait_fall(input string tag);
        logic p;
        bit   found;
        p     = clk_driver;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(posedge clk);
            #1;
            if (p && !clk_driver) found = 1'b1;
            p = clk_driver;
        end
        if (!found) chk({tag, "_fall_timeout"}, 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(3);
        chk("rst_drv", clk_driver, 0);
        chk("rst_tick", tick, 0);
        chk("rst_sw", sw_done, 0);
        chk("rst_running", running, 0);
        chk("rst_sel", active_sel, 0);
        rst = 1'b1;
        step(2);
        chk("idle_running", running, 0);
        chk("idle_drv", clk_driver, 0);

        // Rate 3 (h=4): first rise h after RUN entry, period 8
        set_rate = 3'd3;
        en = 1'b1;
        start_cyc = cyc + 1;
        sw_q.push_back(3);
        push_per(4, 4);
        push_per(8, 4);
        push_per(8, 4);
        step(2);
        chk("run_running", running, 1);
        chk("run_sel", active_sel, 3);
        for (int i = 0; i < 3; i++) wait_rise("r3");

        // Mid-high switch to rate 0 (h=1): current period finishes at h=4
        set_rate = 3'd0;
        sw_q.push_back(0);
        push_per(5, 1);
        push_per(2, 1);
        push_per(2, 1);
        for (int i = 0; i < 3; i++) wait_rise("r0");

        // Mid-high switch to rate 7 (h=8): no runt, then period 16
        set_rate = 3'd7;
        sw_q.push_back(7);
        push_per(9, 8);
        push_per(16, 8);
        for (int i = 0; i < 2; i++) wait_rise("r7");

        // Switch to rate 2 (h=3)
        set_rate = 3'd2;
        sw_q.push_back(2);
        push_per(11, 3);
        wait_rise("r2");

        // Write 0 to the active entry mid-period: this period stays h=3
        cfg_we = 1'b1;
        cfg_idx = 3'd2;
        cfg_half = 24'd0;
        step(1);
        cfg_we = 1'b0;
        push_per(4, 1);
        push_per(2, 1);
        for (int i = 0; i < 2; i++) wait_rise("wr0");

        // Write coinciding with the boundary (h=1): old value used once more
        cfg_we = 1'b1;
        cfg_idx = 3'd2;
        cfg_half = 24'd5;
        push_per(2, 1);
        push_per(6, 5);
        push_per(10, 5);
        step(1);
        cfg_we = 1'b0;
        for (int i = 0; i < 3; i++) wait_rise("wr5");

        // Back to rate 3 (h=4), then drop en mid-high
        set_rate = 3'd3;
        sw_q.push_back(3);
        push_per(9, 4);
        wait_rise("r3b");
        step(1);
        en = 1'b0;
        wait_fall("stop");
        chk("stop_running", running, 0);
        chk("stop_drv", clk_driver, 0);
        step(10);
        chk("park_running", running, 0);
        chk("park_drv", clk_driver, 0);
        chk("park_sel", active_sel, 3);

        // Re-enable at same index: first rise exactly 4 cycles on, no sw_done
        en = 1'b1;
        start_cyc = cyc + 1;
        push_per(4, 4);
        wait_rise("restart");
        chk("restart_running", running, 1);

        // Overwrite entry 5, then async reset mid-count while high
        cfg_we = 1'b1;
        cfg_idx = 3'd5;
        cfg_half = 24'd12;
        step(1);
        cfg_we = 1'b0;
        #3;
        chk("pre_rst_drv", clk_driver, 1);
        rst = 1'b0;
        #1;
        chk("arst_drv", clk_driver, 0);
        chk("arst_running", running, 0);
        chk("arst_tick", tick, 0);
        chk("arst_sel", active_sel, 0);
        en = 1'b0;
        step(3);
        rst = 1'b1;
        step(2);
        chk("post_rst_running", running, 0);

        // Entry 5 is back at its default (h=6)
        set_rate = 3'd5;
        en = 1'b1;
        start_cyc = cyc + 1;
        sw_q.push_back(5);
        push_per(6, 6);
        push_per(12, 6);
        for (int i = 0; i < 2; i++) wait_rise("r5");
        en = 1'b0;
        wait_fall("end");
        step(3);
        chk("end_running", running, 0);
        chk("exp_q_left", exp_q.size(), 0);
        chk("sw_q_left", sw_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
